// File: rtl/hazard_scoreboard_if.sv
// ID-stage hazard scoreboard port bundle: the master drives the decoded instruction
// and flush, and the slave returns the stall, busy map and stall statistic.
interface hazard_scoreboard_if #(
    parameter int REG_AW = 5,
    parameter int STAT_W = 32
);
    localparam int NUM_REGS = 2 ** REG_AW;

    logic                id_valid_in;
    logic [REG_AW-1:0]   id_rs1_in;
    logic                id_rs1_used_in;
    logic [REG_AW-1:0]   id_rs2_in;
    logic                id_rs2_used_in;
    logic [REG_AW-1:0]   id_rd_in;
    logic                id_reg_write_in;
    logic [1:0]          id_class_in;
    logic                flush_in;
    logic                stall_out;
    logic [NUM_REGS-1:0] busy_vec_out;
    logic [STAT_W-1:0]   stall_cycles_out;

    modport master (
        output id_valid_in, id_rs1_in, id_rs1_used_in, id_rs2_in, id_rs2_used_in,
               id_rd_in, id_reg_write_in, id_class_in, flush_in,
        input  stall_out, busy_vec_out, stall_cycles_out
    );

    modport slave (
        input  id_valid_in, id_rs1_in, id_rs1_used_in, id_rs2_in, id_rs2_used_in,
               id_rd_in, id_reg_write_in, id_class_in, flush_in,
        output stall_out, busy_vec_out, stall_cycles_out
    );
endinterface

// File: rtl/hazard_scoreboard.sv
// Per-register countdown scoreboard for multi-cycle results (load/mul/div), with a one-deep
// undo of the last allocation on branch flush and a saturating stall-cycle counter.
module hazard_scoreboard #(
    parameter int REG_AW   = 5,
    parameter int LOAD_LAT = 1,
    parameter int MUL_LAT  = 3,
    parameter int DIV_LAT  = 8,
    parameter int STAT_W   = 32
) (
    input logic                clk,
    input logic                rst,
    hazard_scoreboard_if.slave sb
);
    localparam int NUM_REGS = 2 ** REG_AW;
    localparam int MAX_LM   = (LOAD_LAT > MUL_LAT) ? LOAD_LAT : MUL_LAT;
    localparam int MAX_LAT  = (MAX_LM > DIV_LAT) ? MAX_LM : DIV_LAT;
    localparam int CNT_W    = (MAX_LAT < 1) ? 1 : $clog2(MAX_LAT + 1);

    typedef logic [CNT_W-1:0] cnt_t;

    cnt_t                cnt     [NUM_REGS];
    cnt_t                cnt_nxt [NUM_REGS];
    logic                undo_valid;
    logic [REG_AW-1:0]   undo_rd;
    cnt_t                undo_saved;
    logic [STAT_W-1:0]   stat;
    logic [NUM_REGS-1:0] busy;

    logic hit1, hit2, stall, issue, alloc;
    cnt_t lat, dec_rd;

    always_comb begin
        case (sb.id_class_in)
            2'd1:    lat = cnt_t'(LOAD_LAT);
            2'd2:    lat = cnt_t'(MUL_LAT);
            2'd3:    lat = cnt_t'(DIV_LAT);
            default: lat = '0;
        endcase
    end

    // Hazard checks look at pre-edge counts, so an instruction never stalls on its own rd.
    assign hit1   = sb.id_rs1_used_in && (sb.id_rs1_in != '0) && (cnt[sb.id_rs1_in] != '0);
    assign hit2   = sb.id_rs2_used_in && (sb.id_rs2_in != '0) && (cnt[sb.id_rs2_in] != '0);
    assign stall  = sb.id_valid_in && !sb.flush_in && (hit1 || hit2);
    assign issue  = sb.id_valid_in && !stall && !sb.flush_in;
    assign alloc  = issue && sb.id_reg_write_in && (sb.id_rd_in != '0) && (lat != '0);
    assign dec_rd = (cnt[sb.id_rd_in] == '0) ? '0 : cnt[sb.id_rd_in] - 1'b1;

    always_comb begin
        for (int unsigned r = 0; r < NUM_REGS; r++) begin
            cnt_nxt[REG_AW'(r)] = (cnt[REG_AW'(r)] == '0) ? '0 : cnt[REG_AW'(r)] - 1'b1;
        end
        // Flush suppresses alloc, so the undo branch never competes with a new allocation.
        if (alloc) begin
            cnt_nxt[sb.id_rd_in] = (dec_rd > lat) ? dec_rd : lat;
        end else if (sb.flush_in && undo_valid) begin
            cnt_nxt[undo_rd] = (undo_saved == '0) ? '0 : undo_saved - 1'b1;
        end
        cnt_nxt[0] = '0;
    end

    always_comb begin
        busy = '0;
        for (int unsigned r = 0; r < NUM_REGS; r++) begin
            busy[REG_AW'(r)] = (cnt[REG_AW'(r)] != '0);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned r = 0; r < NUM_REGS; r++) begin
                cnt[REG_AW'(r)] <= '0;
            end
            undo_valid <= 1'b0;
            undo_rd    <= '0;
            undo_saved <= '0;
            stat       <= '0;
        end else begin
            for (int unsigned r = 0; r < NUM_REGS; r++) begin
                cnt[REG_AW'(r)] <= cnt_nxt[REG_AW'(r)];
            end
            undo_valid <= alloc;
            if (alloc) begin
                undo_rd    <= sb.id_rd_in;
                undo_saved <= dec_rd;
            end
            if (stall && (stat != '1)) begin
                stat <= stat + 1'b1;
            end
        end
    end

    assign sb.stall_out        = stall;
    assign sb.busy_vec_out     = busy;
    assign sb.stall_cycles_out = stat;
endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed-vector bench for hazard_scoreboard: stimulus queues hand-computed expectations,
// a negedge monitor pops and compares them against the live outputs.
module tb_hazard_scoreboard;
    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    hazard_scoreboard_if #(.REG_AW(5), .STAT_W(3)) sbif ();

    hazard_scoreboard #(
        .REG_AW(5), .LOAD_LAT(1), .MUL_LAT(3), .DIV_LAT(8), .STAT_W(3)
    ) dut (
        .clk (clk),
        .rst (rst),
        .sb  (sbif)
    );

    typedef struct {
        logic        stall;
        logic [31:0] busy;
        logic [2:0]  stat;
        string       name;
    } exp_t;

    exp_t q[$];
    int   vectors     = 0;
    int   miscompares = 0;

    function automatic logic [31:0] b(input int n);
        logic [31:0] one;
        one = 32'd1;
        return one << n;
    endfunction

    task automatic step(input bit r, input bit v,
                        input logic [4:0] rs1, input bit u1,
                        input logic [4:0] rs2, input bit u2,
                        input logic [4:0] rd, input bit we, input logic [1:0] cls,
                        input bit fl, input bit es, input logic [31:0] eb,
                        input int est, input string nm);
        exp_t e;
        @(posedge clk);
        #1;
        rst                  = r;
        sbif.id_valid_in     = v;
        sbif.id_rs1_in       = rs1;
        sbif.id_rs1_used_in  = u1;
        sbif.id_rs2_in       = rs2;
        sbif.id_rs2_used_in  = u2;
        sbif.id_rd_in        = rd;
        sbif.id_reg_write_in = we;
        sbif.id_class_in     = cls;
        sbif.flush_in        = fl;
        e.stall = es;
        e.busy  = eb;
        e.stat  = 3'(est);
        e.name  = nm;
        q.push_back(e);
    endtask

    task automatic idle(input logic [31:0] eb, input int est, input string nm);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, eb, est, nm);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() != 0) begin
                e = q.pop_front();
                vectors++;
                if (sbif.stall_out !== e.stall) begin
                    miscompares++;
                    $display("FAIL %s stall_out actual=%0b expected=%0b", e.name, sbif.stall_out, e.stall);
                end
                vectors++;
                if (sbif.busy_vec_out !== e.busy) begin
                    miscompares++;
                    $display("FAIL %s busy_vec_out actual=%h expected=%h", e.name, sbif.busy_vec_out, e.busy);
                end
                vectors++;
                if (sbif.stall_cycles_out !== e.stat) begin
                    miscompares++;
                    $display("FAIL %s stall_cycles_out actual=%0d expected=%0d", e.name, sbif.stall_cycles_out, e.stat);
                end
            end
        end
    end

    initial begin : stimulus
        sbif.id_valid_in     = 1'b0;
        sbif.id_rs1_in       = '0;
        sbif.id_rs1_used_in  = 1'b0;
        sbif.id_rs2_in       = '0;
        sbif.id_rs2_used_in  = 1'b0;
        sbif.id_rd_in        = '0;
        sbif.id_reg_write_in = 1'b0;
        sbif.id_class_in     = '0;
        sbif.flush_in        = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        idle(0, 0, "reset_state");
        // load-use, LOAD_LAT=1
        step(0, 1, 0, 0, 0, 0, 5, 1, 1, 0, 0, 0,    0, "ld_x5");
        step(0, 1, 5, 1, 0, 0, 6, 1, 0, 0, 1, b(5), 0, "ld_use_stall");
        step(0, 1, 5, 1, 0, 0, 6, 1, 0, 0, 0, 0,    1, "ld_use_go");
        idle(0, 1, "ld_after");
        // mul then rs2 dependent, MUL_LAT=3
        step(0, 1, 0, 0, 0, 0, 7, 1, 2, 0, 0, 0,    1, "mul_x7");
        step(0, 1, 1, 1, 7, 1, 8, 1, 0, 0, 1, b(7), 1, "mul_use_s1");
        step(0, 1, 1, 1, 7, 1, 8, 1, 0, 0, 1, b(7), 2, "mul_use_s2");
        step(0, 1, 1, 1, 7, 1, 8, 1, 0, 0, 1, b(7), 3, "mul_use_s3");
        step(0, 1, 1, 1, 7, 1, 8, 1, 0, 0, 0, 0,    4, "mul_use_go");
        step(0, 1, 0, 0, 0, 0, 7, 1, 2, 0, 0, 0,    4, "mul_x7_again");
        step(0, 1, 1, 1, 7, 0, 8, 1, 0, 0, 0, b(7), 4, "rs2_unused");
        idle(b(7), 4, "mul_cnt1");
        idle(b(7), 4, "mul_cnt0");
        idle(0,    4, "mul_done");
        // x0 is never tracked
        step(0, 1, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 4, "ld_x0");
        step(0, 1, 0, 1, 0, 1, 3, 1, 0, 0, 0, 0, 4, "read_x0");
        // WAW: div x9 then mul x9 two cycles later keeps the longer count
        step(0, 1, 0, 0, 0, 0, 9, 1, 3, 0, 0, 0,    4, "div_x9");
        idle(b(9), 4, "div_x9_busy");
        step(0, 1, 0, 0, 0, 0, 9, 1, 2, 0, 0, b(9), 4, "mul_x9_waw");
        for (int i = 0; i < 6; i++) begin
            step(0, 1, 9, 1, 0, 0, 10, 1, 0, 0, 1, b(9), (4 + i > 7) ? 7 : 4 + i, "waw_stall");
        end
        step(0, 1, 9, 1, 0, 0, 10, 1, 0, 0, 0, 0, 7, "waw_go");
        // flush undoes a fresh allocation
        step(0, 1, 0, 0, 0, 0, 4, 1, 2, 0, 0, 0,    7, "mul_x4");
        step(0, 1, 4, 1, 0, 0, 0, 0, 0, 1, 0, b(4), 7, "flush_undo");
        step(0, 1, 4, 1, 0, 0, 0, 0, 0, 0, 0, 0,    7, "x4_free");
        // flush restores a pre-existing div count (5 -> saved 4 -> 3)
        step(0, 1, 0, 0, 0, 0, 4, 1, 3, 0, 0, 0,    7, "div_x4");
        idle(b(4), 7, "div_x4_7");
        idle(b(4), 7, "div_x4_6");
        idle(b(4), 7, "div_x4_5");
        step(0, 1, 0, 0, 0, 0, 4, 1, 2, 0, 0, b(4), 7, "mul_x4_over_div");
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, b(4), 7, "flush_restore");
        for (int i = 0; i < 3; i++) begin
            step(0, 1, 4, 1, 0, 0, 0, 0, 0, 0, 1, b(4), 7, "restored_stall");
        end
        step(0, 1, 4, 1, 0, 0, 0, 0, 0, 0, 0, 0, 7, "restored_go");
        // flush in the issue cycle suppresses allocation
        step(0, 1, 0, 0, 0, 0, 11, 1, 2, 1, 0, 0, 7, "flush_alloc");
        idle(0, 7, "no_alloc_x11");
        // async reset mid-countdown
        step(0, 1, 0, 0, 0, 0, 12, 1, 3, 0, 0, 0,     7, "div_x12");
        step(0, 1, 12, 1, 0, 0, 0, 0, 0, 0, 1, b(12), 7, "x12_stall");
        step(1, 1, 12, 1, 0, 0, 0, 0, 0, 0, 0, 0,     0, "async_reset");
        step(0, 1, 12, 1, 0, 0, 0, 0, 0, 0, 0, 0,     0, "post_reset");
        // 10 stall cycles into a 3-bit counter saturate at 7
        step(0, 1, 0, 0, 0, 0, 13, 1, 3, 0, 0, 0, 0, "div_x13");
        for (int i = 0; i < 8; i++) begin
            step(0, 1, 13, 1, 0, 0, 14, 1, 1, 0, 1, b(13), i, "sat_stall");
        end
        step(0, 1, 13, 1, 0, 0, 14, 1, 1, 0, 0, 0,     7, "sat_go");
        step(0, 1, 14, 1, 0, 0, 15, 1, 1, 0, 1, b(14), 7, "sat_ld_stall");
        step(0, 1, 14, 1, 0, 0, 15, 1, 1, 0, 0, 0,     7, "sat_ld_go");
        step(0, 1, 15, 1, 0, 0, 0, 0, 0, 0, 1, b(15),  7, "sat_ld2_stall");
        step(0, 1, 15, 1, 0, 0, 0, 0, 0, 0, 0, 0,      7, "sat_final");

        repeat (3) @(posedge clk);
        if (q.size() != 0) begin
            vectors++;
            miscompares++;
            $display("FAIL drain pending actual=%0d required=0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
